// File: rtl/pulse_receiver_duration_capture.sv
// Pulse receiver: measures high/low phase lengths of an asynchronous line in prescaled units
// and queues {level, duration} entries in a first-word-fall-through FIFO.
module pulse_receiver_duration_capture #(
   parameter int unsigned PRESCALER_WIDTH = 15,
   parameter int unsigned TIMER_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 sys_rst,
   input  logic                                 en,
   input  logic                                 sig_in,
   input  logic                                 invert,
   input  logic [$clog2(PRESCALER_WIDTH+1)-1:0] prescaler,
   input  logic [TIMER_WIDTH-1:0]               idle_threshold,
   input  logic                                 rd_en,
   output logic [TIMER_WIDTH:0]                 rd_data,
   output logic                                 rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
   input  logic                                 clr_overflow,
   output logic                                 overflow,
   output logic                                 busy,
   output logic                                 frame_done
);

   localparam int unsigned CntW   = PRESCALER_WIDTH + TIMER_WIDTH + 1;
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CountW = PtrW + 1;

   localparam logic [CntW-1:0]   CntOne   = CntW'(1);
   localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);
   localparam logic [CountW-1:0] CountOne = CountW'(1);
   localparam logic [CountW-1:0] Depth    = CountW'(FIFO_DEPTH);

   typedef enum logic {StIdle, StMeasure} state_e;

   state_e state_q, state_d;

   logic sync1_q, sync2_q, lvl_q;
   logic lvl, edge_det;

   logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc, cnt_shift;
   logic [TIMER_WIDTH-1:0] dur;
   logic                   cur_level_q, cur_level_d;
   logic                   push, timeout;
   logic                   frame_done_q, overflow_q;

   logic [TIMER_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CountW-1:0]      count_q, count_d;
   logic                   full, do_push, do_pop, drop;

   assign lvl      = sync2_q ^ invert;
   assign edge_det = lvl ^ lvl_q;

   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CntOne;
   assign cnt_shift = cnt_q >> prescaler;
   assign dur       = (|cnt_shift[CntW-1:TIMER_WIDTH]) ? '1 : cnt_shift[TIMER_WIDTH-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_level_d = cur_level_q;
      push        = 1'b0;
      timeout     = 1'b0;
      if (!en) begin
         state_d     = StIdle;
         cnt_d       = '0;
         cur_level_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (edge_det && lvl) begin
                  state_d     = StMeasure;
                  cur_level_d = 1'b1;
                  cnt_d       = CntOne;
               end
            end
            StMeasure: begin
               if (edge_det) begin
                  push        = 1'b1;
                  cnt_d       = CntOne;
                  cur_level_d = lvl;
               end else if (!cur_level_q && (idle_threshold != '0) &&
                            (dur >= idle_threshold)) begin
                  // Line idle long enough: end of frame, the idle phase is not reported
                  timeout = 1'b1;
                  state_d = StIdle;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign full    = (count_q == Depth);
   assign do_pop  = rd_en && (count_q != '0);
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         lvl_q        <= 1'b0;
         cnt_q        <= '0;
         cur_level_q  <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sig_in;
         sync2_q      <= sync1_q;
         lvl_q        <= lvl;
         cnt_q        <= cnt_d;
         cur_level_q  <= cur_level_d;
         frame_done_q <= timeout;
         count_q      <= count_d;
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow) begin
            overflow_q <= 1'b0;
         end
         if (do_push) begin
            mem_q[wr_ptr_q] <= {cur_level_q, dur};
            wr_ptr_q        <= wr_ptr_q + PtrOne;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign rd_valid   = (count_q != '0);
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q == StMeasure);
   assign frame_done = frame_done_q;

endmodule
